instr_cache: RTL and testbench
==============================

# instr_cache

Direct-mapped, read-only instruction cache serving the fetch stage of the pipelined core. Answers each PC lookup combinationally on a hit. On a miss it stalls fetch, refills the whole line from backing memory as an in-order burst, then resumes. It sits between fetch's instruction-address port and the shared memory bus.

## Interface
- DATA_WIDTH, 32: instruction/bus word width
- SETS, 64: number of lines (power of two)
- WORDS_PER_LINE, 4: words per line (power of two, ≥2)
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  1  fetch presents a valid PC
- req_addr_i  in  DATA_WIDTH  byte address (PCF); bits [1:0] ignored
- flush_i  in  1  invalidate all lines (fence.i)
- instr_o  out  DATA_WIDTH  instruction; 0x00000013 (NOP) when not hit
- hit_o  out  1  instr_o valid this cycle
- stall_o  out  1  fetch must hold its PC (drives StallFetch)
- mem_req_o  out  1  burst refill request, held until last beat
- mem_addr_o  out  DATA_WIDTH  line-aligned base byte address of refill
- mem_rvalid_i  in  1  refill beat valid
- mem_rdata_i  in  DATA_WIDTH  refill beat data

## Operation
- Address split:
  - word offset = [log2(WORDS_PER_LINE)+1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
  - Defaults: offset [3:2], index [9:4], tag [31:10].
- Storage: data array SETS×WORDS_PER_LINE words, tag array, valid bit per set.
- hit_o = req_valid_i & valid[index] & (tag match) & (state==IDLE). This is combinational.
- stall_o = (state!=IDLE) | (req_valid_i & ~hit_o).
- FSM states IDLE, REFILL:
  - IDLE, miss:
    - Latch line base address (offset and [1:0] zeroed) into refill_addr.
    - Clear beat counter.
    - Go to REFILL.
  - REFILL:
    - mem_req_o=1 and mem_addr_o=refill_addr.
    - Each cycle with mem_rvalid_i, write mem_rdata_i to word[beat] and increment beat.
    - On beat WORDS_PER_LINE-1 accepted: write tag, set valid, go to IDLE.
- Beats arrive in order, word 0 first. Memory may insert any number of idle cycles between beats.
- mem_rvalid_i in IDLE is ignored.
- req_addr_i changes during REFILL (redirect) do not abort the refill. The new PC is looked up after returning to IDLE.
- Flush:
  - flush_i in IDLE clears all valid bits at the next edge. A hit in that same cycle is still reported.
  - flush_i during REFILL sets flush_pending.
  - At refill completion, all valid bits are cleared, the refilled line is NOT validated, and flush_pending clears.
- Simultaneous flush_i and miss in IDLE: flush applies and the refill starts. The line being refilled is validated normally on completion.

## Timing
- Reset values:
  - state IDLE
  - all valid bits 0
  - flush_pending 0
  - beat counter 0
  - refill_addr 0
  - mem_req_o 0
  - mem_addr_o 0
  - hit_o 0
  - instr_o NOP
  - stall_o = req_valid_i
- Hit latency: 0 cycles (same-cycle result).
- Miss timeline:
  - Cycle 0: miss detected, stall_o=1.
  - Cycle 1: mem_req_o=1.
  - With one beat per cycle on cycles 1..4, cycle 5 is IDLE with hit_o=1.
  - Miss penalty = 1 + beat cycles.
- mem_req_o and mem_addr_o are registered and stable for the whole burst. mem_req_o deasserts the cycle after the last beat.
- Reset asserted mid-refill:
  - Immediately returns to IDLE with mem_req_o=0 and all lines invalid.
  - Memory must abandon the burst.

## Configuration
- ICACHE_STATS_EN:
  - When defined, adds outputs hit_count_o and miss_count_o (32 bits each, reset 0, wrap at 2^32).
  - Counts increment once per IDLE cycle with req_valid_i and hit, and once per IDLE→REFILL transition, respectively.
  - When undefined, the ports and counters do not exist. All other behaviour is identical.

## Test plan
- Cold miss:
  - Stimulus: after reset, req 0x00000000; memory returns 0xA0,0xA1,0xA2,0xA3 on cycles 1..4.
  - Required: mem_addr_o=0x0 and stall_o=1 for cycles 0–4; cycle 5 hit_o=1, instr_o=0xA0.
  - Follow-up: req 0x0000000C then hits with 0xA3 in 0 cycles.
- Gapped burst:
  - Stimulus: beats with 2 idle cycles between each.
  - Required: mem_req_o held high throughout, words stored in order, hit on the cycle after the last beat only.
- Conflict eviction:
  - Stimulus: fill 0x000, then req 0x400 (same index, different tag).
  - Required: miss and refill; a subsequent req 0x000 misses again.
- Flush:
  - Stimulus (IDLE): flush_i in IDLE.
  - Required: next-cycle req to any cached line misses.
  - Stimulus (REFILL): flush_i during REFILL.
  - Required: line not validated and the same PC re-misses.
- Redirect and reset mid-refill:
  - Stimulus: PC changes during REFILL.
  - Required: original line completes, then the new PC is looked up.
  - Stimulus: rst pulsed at beat 2.
  - Required: mem_req_o=0 immediately and the prior line invalid.
- ICACHE_STATS_EN build:
  - Stimulus: 3 misses, 10 hits.
  - Required: miss_count_o=3, hit_count_o=10.

Source files
------------

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, read-only instruction cache with in-order burst line refill.
// Define ICACHE_STATS_EN to add hit_count_o / miss_count_o event counters.
module instr_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  hit_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
`endif
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = DATA_WIDTH - IDX_W - OFF_W - 2;
    localparam int LSB_W = OFF_W + 2;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   refill_addr_q, refill_addr_d;
    logic [OFF_W-1:0]        beat_q, beat_d;
    logic                    flush_pending_q, flush_pending_d;
    logic                    mem_req_q, mem_req_d;
    logic [SETS-1:0]         valid_q, valid_d;

    logic [TAG_W-1:0]        tag_mem  [SETS];
    logic [DATA_WIDTH-1:0]   data_mem [SETS*WORDS_PER_LINE];

    logic [OFF_W-1:0]        req_off;
    logic [IDX_W-1:0]        req_idx, ref_idx;
    logic [TAG_W-1:0]        req_tag, ref_tag;
    logic                    line_wr, tag_wr;
    logic                    unused_bits;

    assign req_off = req_addr_i[LSB_W-1:2];
    assign req_idx = req_addr_i[IDX_W+LSB_W-1:LSB_W];
    assign req_tag = req_addr_i[DATA_WIDTH-1:IDX_W+LSB_W];
    assign ref_idx = refill_addr_q[IDX_W+LSB_W-1:LSB_W];
    assign ref_tag = refill_addr_q[DATA_WIDTH-1:IDX_W+LSB_W];
    assign unused_bits = ^req_addr_i[1:0];

    assign hit_o      = req_valid_i & valid_q[req_idx] & (tag_mem[req_idx] == req_tag) & (state_q == IDLE);
    assign stall_o    = (state_q != IDLE) | (req_valid_i & ~hit_o);
    assign instr_o    = hit_o ? data_mem[{req_idx, req_off}] : NOP;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = refill_addr_q;

    always_comb begin
        state_d         = state_q;
        refill_addr_d   = refill_addr_q;
        beat_d          = beat_q;
        flush_pending_d = flush_pending_q;
        mem_req_d       = mem_req_q;
        valid_d         = valid_q;
        line_wr         = 1'b0;
        tag_wr          = 1'b0;
        case (state_q)
            IDLE: begin
                // A flush and a miss in the same cycle both take effect; the new line is unaffected.
                if (flush_i) valid_d = '0;
                if (req_valid_i && !hit_o) begin
                    refill_addr_d = {req_addr_i[DATA_WIDTH-1:LSB_W], {LSB_W{1'b0}}};
                    beat_d        = '0;
                    mem_req_d     = 1'b1;
                    state_d       = REFILL;
                end
            end
            REFILL: begin
                if (flush_i) flush_pending_d = 1'b1;
                if (mem_rvalid_i) begin
                    line_wr = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == OFF_W'(WORDS_PER_LINE - 1)) begin
                        tag_wr          = 1'b1;
                        mem_req_d       = 1'b0;
                        flush_pending_d = 1'b0;
                        state_d         = IDLE;
                        if (flush_pending_q || flush_i) valid_d = '0;
                        else                            valid_d[ref_idx] = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            refill_addr_q   <= '0;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            mem_req_q       <= 1'b0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            refill_addr_q   <= refill_addr_d;
            beat_q          <= beat_d;
            flush_pending_q <= flush_pending_d;
            mem_req_q       <= mem_req_d;
            valid_q         <= valid_d;
        end
    end

    // Storage arrays carry no reset; valid_q gates every read.
    always_ff @(posedge clk) begin
        if (line_wr) data_mem[{ref_idx, beat_q}] <= mem_rdata_i;
        if (tag_wr)  tag_mem[ref_idx]            <= ref_tag;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + {31'b0, hit_o};
        miss_count_d = miss_count_q + {31'b0, (state_q == IDLE) && (state_d == REFILL)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif
endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: directed scenarios plus randomized accesses against a
// set/tag model of the cache contents and a fixed address->word backing memory.
module tb_instr_cache;
    localparam int W = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid_i = 1'b0, flush_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] req_addr_i = '0, mem_rdata_i = '0;
    logic [31:0] instr_o, mem_addr_o;
    logic        hit_o, stall_o, mem_req_o;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_o, miss_count_o;
`endif

    int checks = 0, errors = 0;
    int exp_hits = 0, exp_misses = 0;
    int gap = 0;

    always #5 clk = ~clk;

    instr_cache dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
        .flush_i(flush_i), .instr_o(instr_o), .hit_o(hit_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef ICACHE_STATS_EN
        , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          miss;
    } exp_t;

    exp_t        q[$];
    bit          mv[64];
    logic [21:0] mt[64];

    function automatic logic [31:0] backing(input logic [31:0] a);
        return 32'h0000_00A0 ^ {2'b00, a[31:2]};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mv[a[9:4]] && (mt[a[9:4]] == a[31:10]);
    endfunction

    task automatic model_clear();
        foreach (mv[i]) mv[i] = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: answers the burst at mem_addr_o in order; junk rvalid while no request is open.
    int rbeat = 0, ridle = 0;
    initial forever begin
        @(posedge clk); #1;
        if (rst || !mem_req_o) begin
            rbeat = 0; ridle = 0;
            mem_rvalid_i = ($urandom_range(0, 3) == 0);
            mem_rdata_i  = $urandom;
        end else if (rbeat < W && (gap < 0 ? ($urandom_range(0, 2) != 0) : (rbeat == 0 || ridle >= gap))) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = backing(mem_addr_o + 32'(4 * rbeat));
            rbeat++; ridle = 0;
        end else begin
            mem_rvalid_i = 1'b0;
            ridle++;
        end
    end

    // Monitor: every hit pops one expected lookup; non-hit cycles must show NOP and stall.
    bit stall_seen = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) stall_seen = 1'b0;
        else if (hit_o) begin
            chk("stall_on_hit", {31'b0, stall_o}, 32'd0);
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_hit: hit at addr %h, none expected", req_addr_i);
            end else begin
                e = q.pop_front();
                chk("instr", instr_o, e.data);
                chk("miss_before_hit", {31'b0, stall_seen}, {31'b0, e.miss});
            end
            stall_seen = 1'b0;
        end else begin
            chk("nop_when_no_hit", instr_o, 32'h0000_0013);
            if (req_valid_i) begin
                chk("stall_on_miss", {31'b0, stall_o}, 32'd1);
                stall_seen = 1'b1;
            end
        end
    end

    // One fetch lookup, held until it hits; optional flush at start / mid-refill and redirect.
    task automatic access(input logic [31:0] a, input bit fl_start, input bit fl_mid,
                          input bit redir, input logic [31:0] ra);
        logic [31:0] cur;
        bit          stalled, hit_now;
        int          cyc;
        cur = a; stalled = 1'b0;
        req_valid_i = 1'b1; req_addr_i = cur; flush_i = fl_start;
        hit_now = model_hit(cur);
        if (fl_start) model_clear();
        for (int k = 0; k < 3 && !hit_now; k++) begin
            stalled = 1'b1; exp_misses++;
            @(posedge clk); #1; flush_i = 1'b0;
            chk("mem_req_start", {31'b0, mem_req_o}, 32'd1);
            if (fl_mid) flush_i = 1'b1;
            if (redir) req_addr_i = ra;
            cyc = 0;
            while (mem_req_o && cyc < 100) begin
                chk("mem_addr", mem_addr_o, {cur[31:4], 4'b0});
                @(posedge clk); #1; flush_i = 1'b0; cyc++;
            end
            chk("refill_done", {31'b0, mem_req_o}, 32'd0);
            if (gap >= 0) chk("refill_cycles", cyc, W + (W - 1) * gap);
            if (fl_mid) model_clear();
            else begin
                mv[cur[9:4]] = 1'b1; mt[cur[9:4]] = cur[31:10];
            end
            fl_mid = 1'b0;
            if (redir) begin cur = ra; redir = 1'b0; end
            hit_now = model_hit(cur);
        end
        if (hit_now) begin
            q.push_back('{cur, backing(cur), stalled});
            exp_hits++;
        end
        @(posedge clk); #1; flush_i = 1'b0; req_valid_i = 1'b0;
        chk("hit_consumed", q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, ra;
        model_clear();
        #12;
        chk("rst_hit", {31'b0, hit_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_stall_idle", {31'b0, stall_o}, 32'd0);
        req_valid_i = 1'b1; #1;
        chk("rst_stall_req", {31'b0, stall_o}, 32'd1);
        req_valid_i = 1'b0;
        @(posedge clk); #1; rst = 1'b0;

        gap = 0;
        access(32'h0000_0000, 0, 0, 0, 0);   // cold miss, back-to-back beats
        access(32'h0000_000C, 0, 0, 0, 0);   // same line, word 3
        gap = 2;
        access(32'h0000_0010, 0, 0, 0, 0);   // gapped burst
        access(32'h0000_0014, 0, 0, 0, 0);
        gap = 0;
        access(32'h0000_0400, 0, 0, 0, 0);   // conflict eviction
        access(32'h0000_0000, 0, 0, 0, 0);
        access(32'h0000_0000, 1, 0, 0, 0);   // hit while flushing
        access(32'h0000_0010, 0, 0, 0, 0);   // flushed line misses
        access(32'h0000_0020, 0, 1, 0, 0);   // flush mid-refill: re-miss
        access(32'h0000_0030, 0, 0, 1, 32'h0000_0040); // redirect
        access(32'h0000_0030, 0, 0, 0, 0);

        // Reset pulsed after two beats of a refill.
        req_valid_i = 1'b1; req_addr_i = 32'h0000_0050;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        chk("midrst_mem_req", {31'b0, mem_req_o}, 32'd0);
        chk("midrst_mem_addr", mem_addr_o, 32'd0);
        chk("midrst_hit", {31'b0, hit_o}, 32'd0);
        model_clear(); exp_hits = 0; exp_misses = 0;
        req_valid_i = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        access(32'h0000_0030, 0, 0, 0, 0);   // prior line must be gone

        gap = -1;
        for (int i = 0; i < 200; i++) begin
            a  = {20'b0, 2'($urandom_range(0, 2)), 4'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b0};
            ra = {20'b0, 2'($urandom_range(0, 2)), 4'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b0};
            access(a, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, ra);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count_o, exp_hits);
        chk("miss_count", miss_count_o, exp_misses);
`endif
        chk("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
